cpu_decode: RTL and testbench
=============================

// Module: cpu_decode
// PURPOSE
//  Decode stage of the Rv32H pipeline, directly downstream of fetch.
//  - Consumes {tag, instruction, pc} from fetch; a new instruction is signalled by a tag change.
//  - Emits registered RV32I decode fields to execute under the same tag-change protocol.
//  - Back-pressures fetch through o_busy, absorbing one in-flight instruction in a skid entry.
// PARAMETERS
//  TAG_W  `TAG_SIZE width (8)  transaction tag width; tags are compared for equality only
// PORTS
//  i_clock        in   1      clock
//  i_reset_n      in   1      asynchronous, active-low reset
//  i_tag          in   TAG_W  fetch output tag
//  i_instruction  in   32     fetch instruction word
//  i_pc           in   32     fetch pc
//  o_busy         out  1      to fetch i_stall; 1 while the skid entry is occupied
//  i_stall        in   1      from execute; 1 = hold decode output
//  o_tag          out  TAG_W  output tag; a change means a new decoded instruction
//  o_pc           out  32     pc of the decoded instruction
//  o_instruction  out  32     raw instruction word
//  o_rd/o_rs1/o_rs2  out  5   register indices, inst[11:7]/[19:15]/[24:20]
//  o_funct3       out  3      inst[14:12]
//  o_funct7_b5    out  1      inst[30] (sub/sra select)
//  o_imm          out  32     sign-extended immediate for the instruction format
//  o_class        out  4      op class, encoded per CPU_Defines.v
//  o_illegal      out  1      unknown opcode, or inst[1:0] != 2'b11
//  o_overflow     out  1      sticky protocol error flag
// BEHAVIOUR
//  - Reset (async, i_reset_n=0): every output is 0.
//    - last_tag=0, so the first tag from fetch (1) is seen as new.
//    - Skid entry is empty.
//  - New input: i_tag != last_tag.
//    - On acceptance, last_tag <= i_tag.
//    - Every new tag is accepted in the cycle it appears.
//  - Output path, when !i_stall:
//    - Skid full: decode the skid entry into the output registers; o_tag <= skid tag.
//    - Otherwise, a new input decodes straight to output; latency is 1 clock from i_tag change to o_tag change.
//  - Stall path, when i_stall:
//    - A new input is captured raw into the skid entry; o_busy=1 from the next cycle.
//  - Simultaneous events, i_stall=0 with skid full and a new input in the same cycle:
//    - Skid drains to output; the new input enters the skid.
//    - o_busy stays 1; program order is preserved.
//  - Skid full with i_stall=1 and a new input arrives (fetch protocol violation):
//    - The input is dropped.
//    - o_overflow <= 1, cleared only by reset.
//  - Outputs hold their value while i_stall=1; o_tag never changes twice for one instruction.
//  - Tag wrap-around (all-ones -> 0) is legal; equality compare only.
//  - Immediate formats, all sign-extended from inst[31]:
//    - I: loads, OP-IMM, JALR, SYSTEM.
//    - S: stores.
//    - B: branches, bit0=0.
//    - U: LUI, AUIPC; low 12 bits = 0.
//    - J: JAL, bit0=0.
//    - R-type: imm=0.
//  - Classes: ALU, ALUI, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, FENCE, SYSTEM, NONE.
//  - Illegal instructions: o_class=NONE, o_illegal=1, still forwarded with their tag (execute traps).
//  - No flush port: fetch waits for branch resolution, so decode never sees wrong-path instructions.
// STRUCTURE
//  - CPU_Defines.v holds `TAG_SIZE, the o_class encodings and the RV32I opcode constants.
//  - One sub-module, cpu_decode_imm: purely combinational instruction -> {imm, class, illegal}.
//    - Instantiated once.
//    - Muxed input: skid entry if full, else live input.
//  - Remaining logic: tag compare, skid register, output registers.
// TESTING
//  - Reset:
//    - Stimulus: pulse i_reset_n low mid-stream with the skid full.
//    - Required: all outputs 0 immediately, o_busy=0, o_overflow=0.
//    - Then tag=1 is accepted.
//  - ADDI:
//    - Stimulus: tag 1, instruction 0xFFF10093, pc 0x100, i_stall=0.
//    - Required, next clock: o_tag=1, rd=1, rs1=2, imm=0xFFFFFFFF, class=ALUI, pc=0x100.
//  - BEQ:
//    - Stimulus: tag 2, instruction 0x00208463.
//    - Required: class=BRANCH, rs1=1, rs2=2, funct3=0, imm=0x00000008.
//  - JAL under stall:
//    - Stimulus: i_stall=1, then tag 3 with instruction 0xFFDFF0EF arrives.
//    - Required: o_tag stays 2 and o_busy=1.
//    - After i_stall=0: o_tag=3, rd=1, imm=0xFFFFFFFC, class=JAL, then o_busy=0.
//  - Back-to-back:
//    - Stimulus: i_stall drops in the same cycle tag 4 arrives while tag 3 sits in the skid.
//    - Required: o_tag=3, then o_tag=4, in order.
//  - Illegal and overflow:
//    - Stimulus: instruction 0x00000000.
//      - Required: o_illegal=1, class=NONE.
//    - Stimulus: two new tags while stalled with skid full.
//      - Required: o_overflow=1, sticky.

Source files
------------

// File: rtl/cpu_decode_pkg.sv
// -----------------------------------------------------------------------------
// cpu_decode_pkg
// Shared definitions for the Rv32H decode stage:
//   - TAG_SIZE      default transaction tag width
//   - OPC_*         RV32I major opcodes (inst[6:0])
//   - op_class_e    op class encoding driven on o_class
//   - dec_fields_t  combinational decode result registered by cpu_decode
// -----------------------------------------------------------------------------
package cpu_decode_pkg;

  localparam int TAG_SIZE = 8;

  // RV32I major opcodes; the two low bits are always 2'b11 for 32-bit encodings.
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // NONE is 0 so that a reset output register reads as "no class".
  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_ALU    = 4'd1,
    CLS_ALUI   = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_JAL    = 4'd6,
    CLS_JALR   = 4'd7,
    CLS_LUI    = 4'd8,
    CLS_AUIPC  = 4'd9,
    CLS_FENCE  = 4'd10,
    CLS_SYSTEM = 4'd11
  } op_class_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic [31:0] imm;
    op_class_e   cls;
    logic        illegal;
  } dec_fields_t;

endpackage : cpu_decode_pkg

// File: rtl/cpu_decode_if.sv
// -----------------------------------------------------------------------------
// cpu_decode_if
// Bundles the fetch-side inputs, the execute-side stall and all decode outputs
// of cpu_decode.
//   slave  : the decode stage (consumes i_*, drives o_*)
//   master : the surrounding pipeline (fetch + execute)
// Signals:
//   i_tag/i_instruction/i_pc  fetch transaction; a tag change marks a new one
//   o_busy                    skid entry occupied (to fetch stall)
//   i_stall                   execute holds the decode outputs
//   o_*                       registered decode result, new on o_tag change
// -----------------------------------------------------------------------------
interface cpu_decode_if #(
  parameter int TAG_W = cpu_decode_pkg::TAG_SIZE
);

  logic [TAG_W-1:0] i_tag;
  logic [31:0]      i_instruction;
  logic [31:0]      i_pc;
  logic             o_busy;
  logic             i_stall;
  logic [TAG_W-1:0] o_tag;
  logic [31:0]      o_pc;
  logic [31:0]      o_instruction;
  logic [4:0]       o_rd;
  logic [4:0]       o_rs1;
  logic [4:0]       o_rs2;
  logic [2:0]       o_funct3;
  logic             o_funct7_b5;
  logic [31:0]      o_imm;
  logic [3:0]       o_class;
  logic             o_illegal;
  logic             o_overflow;

  modport slave (
    input  i_tag, i_instruction, i_pc, i_stall,
    output o_busy, o_tag, o_pc, o_instruction, o_rd, o_rs1, o_rs2,
           o_funct3, o_funct7_b5, o_imm, o_class, o_illegal, o_overflow
  );

  modport master (
    output i_tag, i_instruction, i_pc, i_stall,
    input  o_busy, o_tag, o_pc, o_instruction, o_rd, o_rs1, o_rs2,
           o_funct3, o_funct7_b5, o_imm, o_class, o_illegal, o_overflow
  );

endinterface : cpu_decode_if

// File: rtl/cpu_decode_imm.sv
// -----------------------------------------------------------------------------
// cpu_decode_imm
// Purely combinational RV32I field decoder: instruction word -> register
// indices, funct fields, sign-extended immediate, op class and illegal flag.
// Ports:
//   i_instruction  in   32   instruction word to decode
//   o_dec          out       dec_fields_t decode result
// -----------------------------------------------------------------------------
module cpu_decode_imm
  import cpu_decode_pkg::*;
(
  input  logic [31:0] i_instruction,
  output dec_fields_t o_dec
);

  logic [6:0]  w_opcode;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  assign w_opcode = i_instruction[6:0];

  // All formats sign-extend from inst[31]; B and J carry an implicit bit0 = 0.
  assign w_imm_i = {{20{i_instruction[31]}}, i_instruction[31:20]};
  assign w_imm_s = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
  assign w_imm_b = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                    i_instruction[30:25], i_instruction[11:8], 1'b0};
  assign w_imm_u = {i_instruction[31:12], 12'h000};
  assign w_imm_j = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                    i_instruction[20], i_instruction[30:21], 1'b0};

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // value unassigned; otherwise synthesis would infer a latch.
    o_dec           = '0;
    o_dec.rd        = i_instruction[11:7];
    o_dec.rs1       = i_instruction[19:15];
    o_dec.rs2       = i_instruction[24:20];
    o_dec.funct3    = i_instruction[14:12];
    o_dec.funct7_b5 = i_instruction[30];
    o_dec.cls       = CLS_NONE;
    o_dec.illegal   = 1'b0;

    unique case (w_opcode)
      OPC_OP:       begin o_dec.cls = CLS_ALU;                        end
      OPC_OP_IMM:   begin o_dec.cls = CLS_ALUI;   o_dec.imm = w_imm_i; end
      OPC_LOAD:     begin o_dec.cls = CLS_LOAD;   o_dec.imm = w_imm_i; end
      OPC_STORE:    begin o_dec.cls = CLS_STORE;  o_dec.imm = w_imm_s; end
      OPC_BRANCH:   begin o_dec.cls = CLS_BRANCH; o_dec.imm = w_imm_b; end
      OPC_JAL:      begin o_dec.cls = CLS_JAL;    o_dec.imm = w_imm_j; end
      OPC_JALR:     begin o_dec.cls = CLS_JALR;   o_dec.imm = w_imm_i; end
      OPC_LUI:      begin o_dec.cls = CLS_LUI;    o_dec.imm = w_imm_u; end
      OPC_AUIPC:    begin o_dec.cls = CLS_AUIPC;  o_dec.imm = w_imm_u; end
      OPC_MISC_MEM: begin o_dec.cls = CLS_FENCE;                      end
      OPC_SYSTEM:   begin o_dec.cls = CLS_SYSTEM; o_dec.imm = w_imm_i; end
      default:      begin o_dec.illegal = 1'b1;                       end
    endcase

    // Compressed or reserved encodings: every known opcode already ends in
    // 2'b11, but keep the rule explicit so it survives opcode-table edits.
    if (i_instruction[1:0] != 2'b11) begin
      o_dec.cls     = CLS_NONE;
      o_dec.imm     = '0;
      o_dec.illegal = 1'b1;
    end
  end

endmodule : cpu_decode_imm

// File: rtl/cpu_decode.sv
// -----------------------------------------------------------------------------
// cpu_decode
// Decode stage of the Rv32H pipeline, directly downstream of fetch.
// A new fetch transaction is recognised by a change of i_tag; the decoded
// result is registered and published with its tag on o_tag (1 clock latency
// when not stalled). While execute stalls, one in-flight instruction is held
// raw in a skid entry and o_busy back-pressures fetch. A new tag arriving
// with the skid full and the stall still active is dropped and raises the
// sticky o_overflow flag.
// Ports:
//   i_clock    in  1   clock
//   i_reset_n  in  1   asynchronous active-low reset; all outputs go to 0
//   bus        cpu_decode_if.slave (fetch inputs, stall, decode outputs)
// -----------------------------------------------------------------------------
module cpu_decode
  import cpu_decode_pkg::*;
#(
  parameter int TAG_W = TAG_SIZE
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  cpu_decode_if.slave  bus
);

  // Tag tracking and skid entry
  logic [TAG_W-1:0] r_last_tag;
  logic             r_skid_full;
  logic [TAG_W-1:0] r_skid_tag;
  logic [31:0]      r_skid_instruction;
  logic [31:0]      r_skid_pc;
  logic             r_overflow;

  // Output registers
  logic [TAG_W-1:0] r_out_tag;
  logic [31:0]      r_out_pc;
  logic [31:0]      r_out_instruction;
  dec_fields_t      r_out_dec;

  // Combinational datapath
  logic             w_new;
  logic             w_load_out;
  logic             w_skid_load;
  logic [TAG_W-1:0] w_src_tag;
  logic [31:0]      w_src_instruction;
  logic [31:0]      w_src_pc;
  dec_fields_t      w_dec;

  // Tags are compared for equality only, so wrap-around needs no handling.
  assign w_new = (bus.i_tag != r_last_tag);

  // The skid entry is older than anything on the live input, so it always
  // has priority for the single decoder; this keeps program order.
  assign w_src_tag         = r_skid_full ? r_skid_tag         : bus.i_tag;
  assign w_src_instruction = r_skid_full ? r_skid_instruction : bus.i_instruction;
  assign w_src_pc          = r_skid_full ? r_skid_pc          : bus.i_pc;

  assign w_load_out = !bus.i_stall && (r_skid_full || w_new);

  // The skid captures a new input when it is stalled into an empty skid, or
  // when the skid drains in the same cycle a new input arrives. A new input
  // while stalled with the skid full is the fetch protocol violation: dropped.
  assign w_skid_load = w_new && (bus.i_stall ? !r_skid_full : r_skid_full);

  cpu_decode_imm u_imm (
    .i_instruction (w_src_instruction),
    .o_dec         (w_dec)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_last_tag        <= '0;
      r_skid_full       <= 1'b0;
      r_overflow        <= 1'b0;
      r_out_tag         <= '0;
      r_out_pc          <= '0;
      r_out_instruction <= '0;
      r_out_dec         <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      // Every new tag is consumed in the cycle it appears, even if dropped,
      // so a dropped tag is not re-seen as new on the following cycles.
      if (w_new) begin
        r_last_tag <= bus.i_tag;
      end

      if (w_load_out) begin
        r_out_tag         <= w_src_tag;
        r_out_pc          <= w_src_pc;
        r_out_instruction <= w_src_instruction;
        r_out_dec         <= w_dec;
      end

      if (!bus.i_stall) begin
        // Draining: the skid stays occupied only if a new input refills it.
        r_skid_full <= r_skid_full && w_new;
      end else if (w_new) begin
        if (r_skid_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_skid_full <= 1'b1;
        end
      end
    end
  end

  // NOTE: the skid payload has no reset; r_skid_full alone says whether it
  // holds anything, so resetting the data would only cost reset routing.
  always_ff @(posedge i_clock) begin
    if (w_skid_load) begin
      r_skid_tag         <= bus.i_tag;
      r_skid_instruction <= bus.i_instruction;
      r_skid_pc          <= bus.i_pc;
    end
  end

  assign bus.o_busy        = r_skid_full;
  assign bus.o_overflow    = r_overflow;
  assign bus.o_tag         = r_out_tag;
  assign bus.o_pc          = r_out_pc;
  assign bus.o_instruction = r_out_instruction;
  assign bus.o_rd          = r_out_dec.rd;
  assign bus.o_rs1         = r_out_dec.rs1;
  assign bus.o_rs2         = r_out_dec.rs2;
  assign bus.o_funct3      = r_out_dec.funct3;
  assign bus.o_funct7_b5   = r_out_dec.funct7_b5;
  assign bus.o_imm         = r_out_dec.imm;
  assign bus.o_class       = r_out_dec.cls;
  assign bus.o_illegal     = r_out_dec.illegal;

endmodule : cpu_decode

// File: tb/tb_cpu_decode.sv
// -----------------------------------------------------------------------------
// tb_cpu_decode
// Directed self-checking bench for cpu_decode: decode of each instruction
// format, stall/skid behaviour, back-to-back drain, protocol overflow, tag
// wrap-around and asynchronous reset with the skid full.
// -----------------------------------------------------------------------------
module tb_cpu_decode;
  import cpu_decode_pkg::*;

  localparam int TAG_W = 8;

  logic i_clock;
  logic i_reset_n;
  int   checks;
  int   errors;

  cpu_decode_if #(.TAG_W(TAG_W)) bus ();

  cpu_decode #(.TAG_W(TAG_W)) dut (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  cls;
    logic [31:0] imm;
    logic        ill;
    logic        chk_imm;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic drive(input logic [TAG_W-1:0] tag, input logic [31:0] inst, input logic [31:0] pc);
    bus.i_tag         = tag;
    bus.i_instruction = inst;
    bus.i_pc          = pc;
  endtask

  task automatic check_all_zero(input string prefix);
    check({prefix, "_tag"},      32'(bus.o_tag),         32'h0);
    check({prefix, "_pc"},       bus.o_pc,               32'h0);
    check({prefix, "_inst"},     bus.o_instruction,      32'h0);
    check({prefix, "_rd"},       32'(bus.o_rd),          32'h0);
    check({prefix, "_imm"},      bus.o_imm,              32'h0);
    check({prefix, "_class"},    32'(bus.o_class),       32'h0);
    check({prefix, "_illegal"},  32'(bus.o_illegal),     32'h0);
    check({prefix, "_busy"},     32'(bus.o_busy),        32'h0);
    check({prefix, "_overflow"}, 32'(bus.o_overflow),    32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0] = '{32'h123452B7, CLS_LUI,    32'h12345000, 1'b0, 1'b1}; // lui  x5,0x12345
    vecs[1] = '{32'h80000097, CLS_AUIPC,  32'h80000000, 1'b0, 1'b1}; // auipc x1,0x80000
    vecs[2] = '{32'hFE20AE23, CLS_STORE,  32'hFFFFFFFC, 1'b0, 1'b1}; // sw   x2,-4(x1)
    vecs[3] = '{32'h01022183, CLS_LOAD,   32'h00000010, 1'b0, 1'b1}; // lw   x3,16(x4)
    vecs[4] = '{32'hFF8280E7, CLS_JALR,   32'hFFFFFFF8, 1'b0, 1'b1}; // jalr x1,-8(x5)
    vecs[5] = '{32'h00100073, CLS_SYSTEM, 32'h00000001, 1'b0, 1'b1}; // ebreak
    vecs[6] = '{32'h0FF0000F, CLS_FENCE,  32'h00000000, 1'b0, 1'b0}; // fence
    vecs[7] = '{32'h0000007F, CLS_NONE,   32'h00000000, 1'b1, 1'b0}; // unknown opcode

    // Reset state
    i_reset_n     = 1'b0;
    bus.i_stall   = 1'b0;
    drive(8'd0, 32'h0, 32'h0);
    #2;
    check_all_zero("rst");
    #10 i_reset_n = 1'b1;

    // No tag change yet: nothing is emitted
    tick();
    check("idle_tag", 32'(bus.o_tag), 32'h0);

    // ADDI x1, x2, -1
    drive(8'd1, 32'hFFF10093, 32'h100);
    tick();
    check("addi_tag",   32'(bus.o_tag),     32'd1);
    check("addi_rd",    32'(bus.o_rd),      32'd1);
    check("addi_rs1",   32'(bus.o_rs1),     32'd2);
    check("addi_imm",   bus.o_imm,          32'hFFFFFFFF);
    check("addi_class", 32'(bus.o_class),   32'(CLS_ALUI));
    check("addi_pc",    bus.o_pc,           32'h100);
    check("addi_inst",  bus.o_instruction,  32'hFFF10093);
    check("addi_ill",   32'(bus.o_illegal), 32'h0);
    check("addi_busy",  32'(bus.o_busy),    32'h0);

    // BEQ x1, x2, +8
    drive(8'd2, 32'h00208463, 32'h104);
    tick();
    check("beq_tag",    32'(bus.o_tag),    32'd2);
    check("beq_class",  32'(bus.o_class),  32'(CLS_BRANCH));
    check("beq_rs1",    32'(bus.o_rs1),    32'd1);
    check("beq_rs2",    32'(bus.o_rs2),    32'd2);
    check("beq_funct3", 32'(bus.o_funct3), 32'd0);
    check("beq_imm",    bus.o_imm,         32'h00000008);

    // JAL x1, -4 arrives under stall and sits in the skid
    bus.i_stall = 1'b1;
    tick();
    check("stall_hold_tag", 32'(bus.o_tag), 32'd2);
    drive(8'd3, 32'hFFDFF0EF, 32'h108);
    tick();
    check("jal_stall_tag",  32'(bus.o_tag),  32'd2);
    check("jal_stall_busy", 32'(bus.o_busy), 32'd1);
    tick();
    check("jal_stall_tag2", 32'(bus.o_tag),     32'd2);
    check("jal_stall_imm",  bus.o_imm,          32'h00000008);
    check("jal_stall_ovf",  32'(bus.o_overflow), 32'd0);

    // Stall drops in the same cycle tag 4 (SUB x1,x2,x3) arrives
    bus.i_stall = 1'b0;
    drive(8'd4, 32'h403100B3, 32'h10C);
    tick();
    check("b2b_tag3",   32'(bus.o_tag),   32'd3);
    check("jal_rd",     32'(bus.o_rd),    32'd1);
    check("jal_imm",    bus.o_imm,        32'hFFFFFFFC);
    check("jal_class",  32'(bus.o_class), 32'(CLS_JAL));
    check("jal_pc",     bus.o_pc,         32'h108);
    check("b2b_busy",   32'(bus.o_busy),  32'd1);
    tick();
    check("b2b_tag4",   32'(bus.o_tag),       32'd4);
    check("sub_class",  32'(bus.o_class),     32'(CLS_ALU));
    check("sub_f7b5",   32'(bus.o_funct7_b5), 32'd1);
    check("sub_imm",    bus.o_imm,            32'h0);
    check("sub_pc",     bus.o_pc,             32'h10C);
    check("b2b_busy0",  32'(bus.o_busy),      32'd0);

    // Remaining formats, one tag each
    for (int i = 0; i < 8; i++) begin
      drive(8'(5 + i), vecs[i].inst, 32'h180 + 32'(4 * i));
      tick();
      check($sformatf("vec%0d_tag", i),   32'(bus.o_tag),     32'(5 + i));
      check($sformatf("vec%0d_class", i), 32'(bus.o_class),   32'(vecs[i].cls));
      check($sformatf("vec%0d_ill", i),   32'(bus.o_illegal), 32'(vecs[i].ill));
      if (vecs[i].chk_imm) begin
        check($sformatf("vec%0d_imm", i), bus.o_imm, vecs[i].imm);
      end
    end

    // All-zero word: inst[1:0] != 2'b11
    drive(8'd13, 32'h00000000, 32'h200);
    tick();
    check("zero_tag",   32'(bus.o_tag),     32'd13);
    check("zero_ill",   32'(bus.o_illegal), 32'd1);
    check("zero_class", 32'(bus.o_class),   32'(CLS_NONE));

    // Overflow: two new tags while stalled with the skid full
    bus.i_stall = 1'b1;
    drive(8'd14, 32'hFFF10093, 32'h204);
    tick();
    check("ovf_busy",  32'(bus.o_busy),     32'd1);
    check("ovf_pre",   32'(bus.o_overflow), 32'd0);
    drive(8'd15, 32'h00208463, 32'h208);
    tick();
    check("ovf_set",   32'(bus.o_overflow), 32'd1);
    check("ovf_hold",  32'(bus.o_tag),      32'd13);
    drive(8'd16, 32'h403100B3, 32'h20C);
    tick();
    check("ovf_set2",  32'(bus.o_overflow), 32'd1);
    bus.i_stall = 1'b0;
    tick();
    check("ovf_drain_tag",   32'(bus.o_tag),     32'd14);
    check("ovf_drain_pc",    bus.o_pc,           32'h204);
    check("ovf_drain_class", 32'(bus.o_class),   32'(CLS_ALUI));
    check("ovf_sticky",      32'(bus.o_overflow), 32'd1);
    tick();
    check("ovf_dropped_tag", 32'(bus.o_tag),      32'd14);
    check("ovf_busy0",       32'(bus.o_busy),     32'd0);
    check("ovf_sticky2",     32'(bus.o_overflow), 32'd1);

    // Tag wrap-around 0xFF -> 0x00
    drive(8'hFF, 32'h123452B7, 32'h300);
    tick();
    check("wrap_ff", 32'(bus.o_tag), 32'h0FF);
    drive(8'h00, 32'h80000097, 32'h304);
    tick();
    check("wrap_00_tag", 32'(bus.o_tag), 32'h0);
    check("wrap_00_pc",  bus.o_pc,       32'h304);

    // Asynchronous reset mid-stream with the skid full
    bus.i_stall = 1'b1;
    drive(8'd1, 32'hFFDFF0EF, 32'h308);
    tick();
    check("mid_busy", 32'(bus.o_busy), 32'd1);
    #2 i_reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    bus.i_stall = 1'b0;
    drive(8'd1, 32'hFFF10093, 32'h400);
    #2 i_reset_n = 1'b1;
    tick();
    check("post_rst_tag",   32'(bus.o_tag),      32'd1);
    check("post_rst_pc",    bus.o_pc,            32'h400);
    check("post_rst_class", 32'(bus.o_class),    32'(CLS_ALUI));
    check("post_rst_busy",  32'(bus.o_busy),     32'd0);
    check("post_rst_ovf",   32'(bus.o_overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cpu_decode
